// File: rtl/cfeb_link_sync_monitor_pkg.sv
// cfeb_sync_pkg: shared state encoding, arm-counter width and default frame markers for the CFEB sync monitor.
package cfeb_sync_pkg;
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_SYNCED  = 3'd2,
      ST_SUSPECT = 3'd3,
      ST_LOST    = 3'd4
   } state_t;
   localparam int ARMW = 5;
   localparam logic [7:0] KCHAR_A_DEF = 8'hBC;
   localparam logic [7:0] KCHAR_B_DEF = 8'hFC;
   // A group is judged on its markers only once it has finished arming.
   function automatic logic is_checking(state_t s);
      return s == ST_SYNCED || s == ST_SUSPECT || s == ST_LOST;
   endfunction
endpackage

// File: rtl/cfeb_link_sync_monitor_if.sv
// cfeb_link_sync_monitor_if: link inputs, control and status bundle of the CFEB sync monitor.
interface cfeb_link_sync_monitor_if #(
   parameter int NCH  = 7,
   parameter int NGRP = 2,
   parameter int ERRW = 16
);
   logic                 ttc_resync;
   logic [NCH*8-1:0]     kchar;
   logic [NCH-1:0]       link_good;
   logic [NCH-1:0]       fiber_enable;
   logic [NCH-1:0]       sync_done;
   logic [NGRP*4-1:0]    rxd_delay;
   logic [7:0]           kchar_a;
   logic [7:0]           kchar_b;
   logic [3:0]           lost_thresh;
   logic                 errcnt_clear;
   logic [NGRP-1:0]      grp_synced;
   logic [NGRP-1:0]      grp_lostsync;
   logic [NGRP*3-1:0]    grp_state;
   logic [NGRP*ERRW-1:0] grp_errcnt;
   logic [NCH-1:0]       ch_bad;
   modport master (
      output ttc_resync, kchar, link_good, fiber_enable, sync_done, rxd_delay,
             kchar_a, kchar_b, lost_thresh, errcnt_clear,
      input  grp_synced, grp_lostsync, grp_state, grp_errcnt, ch_bad
   );
   modport slave (
      input  ttc_resync, kchar, link_good, fiber_enable, sync_done, rxd_delay,
             kchar_a, kchar_b, lost_thresh, errcnt_clear,
      output grp_synced, grp_lostsync, grp_state, grp_errcnt, ch_bad
   );
endinterface

// File: rtl/cfeb_link_sync_monitor_grp_fsm.sv
// cfeb_sync_grp_fsm: per-group arm/synced/suspect/lost tracker with arm delay, bad-run and saturating error counters.
module cfeb_sync_grp_fsm
   import cfeb_sync_pkg::*;
#(
   parameter int ERRW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            match_i,
   input  logic            sync_done_i,
   input  logic            ttc_resync_i,
   input  logic            errcnt_clear_i,
   input  logic [3:0]      rxd_delay_i,
   input  logic [3:0]      lost_thresh_i,
   output state_t          state_o,
   output logic            synced_o,
   output logic            lostsync_o,
   output logic [ERRW-1:0] errcnt_o
);
   state_t            state_q, state_d;
   logic [ARMW-1:0]   arm_q, arm_d;
   logic [3:0]        bad_q, bad_d, thr;
   logic              synced_q, synced_d, lost_q, lost_d;
   logic [ERRW-1:0]   err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         arm_q    <= '0;
         bad_q    <= '0;
         synced_q <= 1'b1;
         lost_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         arm_q    <= arm_d;
         bad_q    <= bad_d;
         synced_q <= synced_d;
         lost_q   <= lost_d;
         err_q    <= err_d;
      end
   end

   assign thr = (lost_thresh_i == 4'd0) ? 4'd1 : lost_thresh_i;

   always_comb begin
      state_d = state_q;
      arm_d   = arm_q;
      bad_d   = bad_q;
      case (state_q)
         ST_IDLE: if (sync_done_i) begin
            state_d = ST_ARM;
            arm_d   = ARMW'(rxd_delay_i) + ARMW'(1);
         end
         ST_ARM: begin
            arm_d   = arm_q - ARMW'(1);
            state_d = (arm_q == ARMW'(1)) ? ST_SYNCED : ST_ARM;
         end
         ST_SYNCED: if (!match_i) begin
            bad_d   = 4'd1;
            state_d = (thr == 4'd1) ? ST_LOST : ST_SUSPECT;
         end
         ST_SUSPECT: begin
            bad_d   = match_i ? 4'd0 : bad_q + 4'd1;
            state_d = match_i ? ST_SYNCED : (bad_q + 4'd1 >= thr) ? ST_LOST : ST_SUSPECT;
         end
         default: state_d = state_q;
      endcase
      if (ttc_resync_i || !sync_done_i) state_d = ST_IDLE;
      synced_d = is_checking(state_d) ? match_i : 1'b1;
      lost_d   = ttc_resync_i ? 1'b0 : lost_q | (state_d == ST_LOST);
      err_d    = errcnt_clear_i ? '0 :
                 (!match_i && is_checking(state_q) && !(&err_q)) ? err_q + ERRW'(1) : err_q;
   end

   assign state_o    = state_q;
   assign synced_o   = synced_q;
   assign lostsync_o = lost_q;
   assign errcnt_o   = err_q;
endmodule

// File: rtl/cfeb_link_sync_monitor.sv
// cfeb_link_sync_monitor: per-group CFEB fiber frame-marker agreement monitor with lost-sync tracking and culprit flags.
module cfeb_link_sync_monitor
   import cfeb_sync_pkg::*;
#(
   parameter int                  NCH      = 7,
   parameter int                  NGRP     = 2,
   parameter logic [NGRP*NCH-1:0] GRP_MASK = {7'h70, 7'h0F},
   parameter int                  ERRW     = 16
) (
   input logic                     clk,
   input logic                     rst_n,
   cfeb_link_sync_monitor_if.slave bus
);
   logic [NCH-1:0]       lg1_q, lg2_q, act, in_set, is_a, chk, ch_bad_q, ch_bad_d;
   logic [NGRP-1:0]      match, gsd, checking, syn, lost;
   logic [NGRP*ERRW-1:0] err;
   state_t               st [NGRP];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lg1_q    <= '0;
         lg2_q    <= '0;
         ch_bad_q <= '0;
      end else begin
         lg1_q    <= bus.link_good;
         lg2_q    <= lg1_q;
         ch_bad_q <= ch_bad_d;
      end
   end

   // A falling link_good drops the channel at once; a rising one must hold for two edges.
   assign act = bus.fiber_enable & bus.link_good & lg2_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign in_set[i] = bus.kchar[8*i +: 8] == bus.kchar_a || bus.kchar[8*i +: 8] == bus.kchar_b;
      assign is_a[i]   = bus.kchar[8*i +: 8] == bus.kchar_a;
   end

   for (genvar g = 0; g < NGRP; g++) begin : g_grp
      localparam logic [NCH-1:0] M = GRP_MASK[g*NCH +: NCH];
      logic [NCH-1:0] ga;
      assign ga = act & M;
      // All members legal markers, and not a mix of kchar_a and non-kchar_a.
      assign match[g]    = !(|(ga & ~in_set)) && !(|(ga & is_a) && |(ga & ~is_a));
      assign gsd[g]      = &(bus.sync_done | ~M);
      assign checking[g] = is_checking(st[g]);
      cfeb_sync_grp_fsm #(.ERRW(ERRW)) u_fsm (
         .clk           (clk),
         .rst_n         (rst_n),
         .match_i       (match[g]),
         .sync_done_i   (gsd[g]),
         .ttc_resync_i  (bus.ttc_resync),
         .errcnt_clear_i(bus.errcnt_clear),
         .rxd_delay_i   (bus.rxd_delay[4*g +: 4]),
         .lost_thresh_i (bus.lost_thresh),
         .state_o       (st[g]),
         .synced_o      (syn[g]),
         .lostsync_o    (lost[g]),
         .errcnt_o      (err[g*ERRW +: ERRW])
      );
      assign bus.grp_state[3*g +: 3] = st[g];
   end

   always_comb begin
      chk = '0;
      for (int g = 0; g < NGRP; g++) chk = chk | (GRP_MASK[g*NCH +: NCH] & {NCH{checking[g]}});
   end

   assign ch_bad_d         = bus.errcnt_clear ? '0 : ch_bad_q | (act & ~in_set & chk);
   assign bus.ch_bad       = ch_bad_q;
   assign bus.grp_synced   = syn;
   assign bus.grp_lostsync = lost;
   assign bus.grp_errcnt   = err;
endmodule

// File: tb/tb_cfeb_link_sync_monitor.sv
// tb_cfeb_link_sync_monitor: directed stimulus against a rule-level model of the CFEB sync monitor, checked every cycle.
module tb_cfeb_link_sync_monitor;
   import cfeb_sync_pkg::*;
   localparam int NCH  = 7;
   localparam int NGRP = 2;
   localparam int ERRW = 6;
   localparam logic [NGRP*NCH-1:0] MASK = {7'h70, 7'h0F};
   localparam int PH_IDLE = 0, PH_ARM = 1, PH_SYNC = 2, PH_SUSP = 3, PH_LOST = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   cfeb_link_sync_monitor_if #(.NCH(NCH), .NGRP(NGRP), .ERRW(ERRW)) bus ();

   cfeb_link_sync_monitor #(.NCH(NCH), .NGRP(NGRP), .GRP_MASK(MASK), .ERRW(ERRW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int             m_ph [NGRP];
   int             m_left [NGRP];
   int             m_run [NGRP];
   int             m_err [NGRP];
   bit             m_syn [NGRP];
   bit             m_lost [NGRP];
   bit [NCH-1:0]   m_chbad, lg_p1, lg_p2;
   logic [NCH-1:0] gmask [NGRP];

   function automatic bit ch_active(int i);
      return bus.fiber_enable[i] && bus.link_good[i] && lg_p2[i];
   endfunction

   function automatic logic [7:0] kc(int i);
      return bus.kchar[8*i +: 8];
   endfunction

   function automatic bit ok_marker(logic [7:0] v);
      return v == bus.kchar_a || v == bus.kchar_b;
   endfunction

   // Collect the active members' markers: none, or one common legal value.
   function automatic bit grp_match(int g);
      int         seen = 0;
      logic [7:0] first = 8'h00;
      bit         same = 1'b1;
      for (int i = 0; i < NCH; i++)
         if (gmask[g][i] && ch_active(i)) begin
            if (seen == 0) first = kc(i);
            else if (kc(i) != first) same = 1'b0;
            seen++;
         end
      return seen == 0 || (same && ok_marker(first));
   endfunction

   task automatic model_reset();
      for (int g = 0; g < NGRP; g++) begin
         m_ph[g] = PH_IDLE; m_left[g] = 0; m_run[g] = 0; m_err[g] = 0;
         m_syn[g] = 1'b1; m_lost[g] = 1'b0;
      end
      m_chbad = '0; lg_p1 = '0; lg_p2 = '0;
   endtask

   task automatic model_step();
      bit mt [NGRP];
      int thr, ns;
      thr = (bus.lost_thresh == 4'd0) ? 1 : int'(bus.lost_thresh);
      for (int g = 0; g < NGRP; g++) mt[g] = grp_match(g);
      if (bus.errcnt_clear) m_chbad = '0;
      else
         for (int i = 0; i < NCH; i++)
            if (ch_active(i) && !ok_marker(kc(i)))
               for (int g = 0; g < NGRP; g++)
                  if (gmask[g][i] && m_ph[g] >= PH_SYNC) m_chbad[i] = 1'b1;
      for (int g = 0; g < NGRP; g++) begin
         if (bus.errcnt_clear) m_err[g] = 0;
         else if (m_ph[g] >= PH_SYNC && !mt[g] && m_err[g] < (1 << ERRW) - 1) m_err[g]++;
         ns = m_ph[g];
         if (bus.ttc_resync || (bus.sync_done & gmask[g]) != gmask[g]) ns = PH_IDLE;
         else if (m_ph[g] == PH_IDLE) begin
            ns = PH_ARM;
            m_left[g] = int'(bus.rxd_delay[4*g +: 4]) + 1;
         end else if (m_ph[g] == PH_ARM) begin
            m_left[g]--;
            if (m_left[g] == 0) ns = PH_SYNC;
         end else if (m_ph[g] != PH_LOST) begin
            if (mt[g]) ns = PH_SYNC;
            else begin
               m_run[g]++;
               ns = (m_run[g] >= thr) ? PH_LOST : PH_SUSP;
            end
         end
         if (ns != PH_SUSP) m_run[g] = 0;
         m_syn[g]  = (ns <= PH_ARM) ? 1'b1 : mt[g];
         m_lost[g] = bus.ttc_resync ? 1'b0 : (m_lost[g] || ns == PH_LOST);
         m_ph[g]   = ns;
      end
      lg_p2 = lg_p1;
      lg_p1 = bus.link_good;
   endtask

   task automatic check(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int st(int g);  return int'(bus.grp_state[3*g +: 3]);    endfunction
   function automatic int syn(int g); return int'(bus.grp_synced[g]);          endfunction
   function automatic int lst(int g); return int'(bus.grp_lostsync[g]);        endfunction
   function automatic int err(int g); return int'(bus.grp_errcnt[ERRW*g +: ERRW]); endfunction

   task automatic compare();
      for (int g = 0; g < NGRP; g++) begin
         check($sformatf("state%0d", g), st(g), m_ph[g]);
         check($sformatf("synced%0d", g), syn(g), int'(m_syn[g]));
         check($sformatf("lostsync%0d", g), lst(g), int'(m_lost[g]));
         check($sformatf("errcnt%0d", g), err(g), m_err[g]);
      end
      check("ch_bad", int'(bus.ch_bad), int'(m_chbad));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic set_kc(int i, logic [7:0] v);
      bus.kchar[8*i +: 8] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int g = 0; g < NGRP; g++) gmask[g] = MASK[g*NCH +: NCH];
      bus.ttc_resync   = 1'b0;
      bus.kchar        = {NCH{KCHAR_A_DEF}};
      bus.link_good    = '1;
      bus.fiber_enable = '1;
      bus.sync_done    = '0;
      bus.rxd_delay    = {NGRP{4'd3}};
      bus.kchar_a      = KCHAR_A_DEF;
      bus.kchar_b      = KCHAR_B_DEF;
      bus.lost_thresh  = 4'd3;
      bus.errcnt_clear = 1'b0;
      model_reset();
      #12;
      for (int g = 0; g < NGRP; g++) begin
         check("rst_state", st(g), 0);
         check("rst_synced", syn(g), 1);
         check("rst_lost", lst(g), 0);
         check("rst_err", err(g), 0);
      end
      check("rst_chbad", int'(bus.ch_bad), 0);
      rst_n = 1'b1;
      repeat (2) tick();
      // Arming with rxd_delay=3
      bus.sync_done = '1;
      tick();
      check("arm_g0", st(0), 1);
      check("arm_g1", st(1), 1);
      repeat (3) tick();
      check("still_arm_g0", st(0), 1);
      tick();
      check("synced_g0", st(0), 2);
      check("synced_g1", st(1), 2);
      check("synced_flags", int'(bus.grp_synced), 3);
      // Two bad frames on CFEB2 then recovery
      set_kc(2, 8'h3C);
      tick();
      check("t2_suspect", st(0), 3);
      check("t2_chbad2", int'(bus.ch_bad[2]), 1);
      check("t2_synced0", syn(0), 0);
      tick();
      check("t2_suspect2", st(0), 3);
      set_kc(2, KCHAR_A_DEF);
      tick();
      check("t2_resynced", st(0), 2);
      check("t2_err0", err(0), 2);
      check("t2_lost0", lst(0), 0);
      check("t2_synced0b", syn(0), 1);
      bus.errcnt_clear = 1'b1;
      tick();
      bus.errcnt_clear = 1'b0;
      check("clr_err0", err(0), 0);
      check("clr_chbad", int'(bus.ch_bad), 0);
      // Three bad frames -> LOST, then resync
      set_kc(2, 8'h3C);
      repeat (2) tick();
      check("t3_notlost", lst(0), 0);
      tick();
      check("t3_lost_state", st(0), 4);
      check("t3_lost_flag", lst(0), 1);
      set_kc(2, KCHAR_A_DEF);
      repeat (2) tick();
      check("t3_absorb", st(0), 4);
      bus.ttc_resync = 1'b1;
      tick();
      bus.ttc_resync = 1'b0;
      check("ttc_idle", st(0), 0);
      check("ttc_lost", lst(0), 0);
      check("ttc_synced", syn(0), 1);
      repeat (5) tick();
      check("rearm_synced", st(0), 2);
      // CFEB5 disagrees in group 1, then is disabled
      set_kc(5, KCHAR_B_DEF);
      tick();
      check("t4_g1_mis", syn(1), 0);
      check("t4_g0_ok", syn(0), 1);
      check("t4_g1_susp", st(1), 3);
      bus.fiber_enable[5] = 1'b0;
      tick();
      check("t4_g1_match", syn(1), 1);
      check("t4_g1_synced", st(1), 2);
      bus.fiber_enable[5] = 1'b1;
      set_kc(5, KCHAR_A_DEF);
      tick();
      // Group 0 links down: garbage ignored
      check("t5_err_pin", m_err[0], 3);
      bus.link_good[3:0] = 4'h0;
      repeat (6) begin
         for (int i = 0; i < 4; i++) set_kc(i, 8'($urandom));
         tick();
         check("t5_synced0", syn(0), 1);
      end
      check("t5_err0", err(0), 3);
      for (int i = 0; i < 4; i++) set_kc(i, KCHAR_A_DEF);
      set_kc(0, 8'h3C);
      bus.link_good[3:0] = 4'hF;
      repeat (2) tick();
      check("t5_pending", syn(0), 1);
      tick();
      check("t5_resumed", syn(0), 0);
      check("t5_susp", st(0), 3);
      set_kc(0, KCHAR_A_DEF);
      tick();
      check("t5_back", st(0), 2);
      // Threshold 0 acts as 1; drive the counter into saturation
      bus.lost_thresh  = 4'd0;
      bus.errcnt_clear = 1'b1;
      tick();
      bus.errcnt_clear = 1'b0;
      set_kc(0, 8'h3C);
      tick();
      check("t6_direct_lost", st(0), 4);
      check("t6_lost_flag", lst(0), 1);
      repeat ((1 << ERRW) + 4) tick();
      check("t6_saturated", err(0), (1 << ERRW) - 1);
      bus.errcnt_clear = 1'b1;
      tick();
      check("t6_clear_wins", err(0), 0);
      bus.errcnt_clear = 1'b0;
      tick();
      check("t6_count_again", err(0), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
